// File: rtl/wb_scoreboard.sv
// Regfile write-port arbiter (ALU over LU) plus long-latency destination scoreboard with decode stall.
// Latency: stall/lu_wb_ready/rf_* combinational; pend_cnt/sb_err one edge late. Backpressure: LU via lu_wb_ready, decode via stall.
module wb_scoreboard #(
  parameter int WIDTH      = 32,
  parameter int ADDR       = 5,
  parameter int MAX_PEND   = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [ADDR-1:0]  issue_rs1,
  input  logic [ADDR-1:0]  issue_rs2,
  input  logic [ADDR-1:0]  issue_rd,
  input  logic             issue_rd_en,
  input  logic             issue_long,
  output logic             stall,
  input  logic             alu_wb_valid,
  input  logic [ADDR-1:0]  alu_wb_rd,
  input  logic [WIDTH-1:0] alu_wb_data,
  input  logic             lu_wb_valid,
  input  logic [ADDR-1:0]  lu_wb_rd,
  input  logic [WIDTH-1:0] lu_wb_data,
  output logic             lu_wb_ready,
  output logic             rf_wr_en,
  output logic [ADDR-1:0]  rf_rd,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [ADDR:0]    pend_cnt,
  output logic             sb_err
);

  localparam int NREG = 1 << ADDR;
  localparam int WW   = $clog2(STARVE_LIM + 1);

  localparam logic [ADDR:0]   PEND_MAX = (ADDR+1)'(MAX_PEND);
  localparam logic [ADDR:0]   PEND_ONE = (ADDR+1)'(1);
  localparam logic [WW-1:0]   WAIT_MAX = WW'(STARVE_LIM);
  localparam logic [WW-1:0]   WAIT_ONE = WW'(1);
  localparam logic [NREG-1:0] REG_ONE  = NREG'(1);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] ebusy;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [ADDR:0]   pend_d;
  logic [WW-1:0]   wait_cnt;
  logic [WW-1:0]   wait_d;
  logic            starve;
  logic            starve_d;

  logic alu_take;
  logic lu_fire;
  logic lu_wr;
  logic hz1;
  logic hz2;
  logic hzd;
  logic full;
  logic issue_fire;
  logic set_en;
  logic clr_en;
  logic err_ev;

  // ALU owns the port whenever it has a real destination; x0 writes never occupy it.
  assign alu_take    = !reset && alu_wb_valid && (alu_wb_rd != '0);
  assign lu_wb_ready = !reset && !alu_take;
  assign lu_fire     = lu_wb_valid && lu_wb_ready;
  assign lu_wr       = lu_fire && (lu_wb_rd != '0);

  always_comb begin
    rf_wr_en = 1'b0;
    rf_rd    = '0;
    rf_wdata = '0;
    if (alu_take) begin
      rf_wr_en = 1'b1;
      rf_rd    = alu_wb_rd;
      rf_wdata = alu_wb_data;
    end else if (lu_wr) begin
      rf_wr_en = 1'b1;
      rf_rd    = lu_wb_rd;
      rf_wdata = lu_wb_data;
    end
  end

  // A result landing this cycle is forwarded by the regfile's negedge write.
  assign clr_mask = lu_wr ? (REG_ONE << lu_wb_rd) : '0;
  assign ebusy    = busy & ~clr_mask;

  assign hz1  = (issue_rs1 != '0) && ebusy[issue_rs1];
  assign hz2  = (issue_rs2 != '0) && ebusy[issue_rs2];
  assign hzd  = issue_rd_en && (issue_rd != '0) && ebusy[issue_rd];
  assign full = issue_long && issue_rd_en && (issue_rd != '0) &&
                (pend_cnt == PEND_MAX) && !lu_fire;

  assign stall      = reset || starve || (issue_valid && (hz1 || hz2 || hzd || full));
  assign issue_fire = issue_valid && !stall;

  assign set_en   = issue_fire && issue_long && issue_rd_en && (issue_rd != '0);
  assign set_mask = set_en ? (REG_ONE << issue_rd) : '0;
  assign clr_en   = lu_wr && busy[lu_wb_rd];
  assign err_ev   = lu_wr && !busy[lu_wb_rd];

  always_comb begin
    busy_d = (busy | set_mask) & ~(clr_en ? clr_mask : '0) & ~REG_ONE;
    pend_d = pend_cnt;
    if (set_en && !clr_en) begin
      pend_d = pend_cnt + PEND_ONE;
    end else if (!set_en && clr_en) begin
      pend_d = pend_cnt - PEND_ONE;
    end
  end

  // Starvation counter saturates; the flag holds until the LU finally gets the port.
  always_comb begin
    wait_d = wait_cnt;
    if (lu_fire || !lu_wb_valid) begin
      wait_d = '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_d = wait_cnt + WAIT_ONE;
    end
    starve_d = !lu_fire && (starve || (wait_cnt == WAIT_MAX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      pend_cnt <= '0;
      wait_cnt <= '0;
      starve   <= 1'b0;
      sb_err   <= 1'b0;
    end else begin
      busy     <= busy_d;
      pend_cnt <= pend_d;
      wait_cnt <= wait_d;
      starve   <= starve_d;
      sb_err   <= sb_err | err_ev;
    end
  end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard: hazard stalls, port arbitration, capacity, starvation, errors, reset.
module tb_wb_scoreboard;

  localparam int WIDTH = 32;
  localparam int ADDR  = 5;

  logic             clk;
  logic             reset;
  logic             issue_valid;
  logic [ADDR-1:0]  issue_rs1;
  logic [ADDR-1:0]  issue_rs2;
  logic [ADDR-1:0]  issue_rd;
  logic             issue_rd_en;
  logic             issue_long;
  logic             stall;
  logic             alu_wb_valid;
  logic [ADDR-1:0]  alu_wb_rd;
  logic [WIDTH-1:0] alu_wb_data;
  logic             lu_wb_valid;
  logic [ADDR-1:0]  lu_wb_rd;
  logic [WIDTH-1:0] lu_wb_data;
  logic             lu_wb_ready;
  logic             rf_wr_en;
  logic [ADDR-1:0]  rf_rd;
  logic [WIDTH-1:0] rf_wdata;
  logic [ADDR:0]    pend_cnt;
  logic             sb_err;

  int n_checks = 0;
  int n_errs   = 0;

  wb_scoreboard #(.WIDTH(WIDTH), .ADDR(ADDR), .MAX_PEND(4), .STARVE_LIM(8)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_rd_en(issue_rd_en), .issue_long(issue_long),
    .stall(stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .lu_wb_valid(lu_wb_valid), .lu_wb_rd(lu_wb_rd), .lu_wb_data(lu_wb_data),
    .lu_wb_ready(lu_wb_ready),
    .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .pend_cnt(pend_cnt), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic drive_issue(input logic v, input int rs1, input int rs2, input int rd,
                             input logic rd_en, input logic lng);
    issue_valid = v;
    issue_rs1   = ADDR'(rs1);
    issue_rs2   = ADDR'(rs2);
    issue_rd    = ADDR'(rd);
    issue_rd_en = rd_en;
    issue_long  = lng;
  endtask

  task automatic drive_alu(input logic v, input int rd, input logic [WIDTH-1:0] d);
    alu_wb_valid = v;
    alu_wb_rd    = ADDR'(rd);
    alu_wb_data  = d;
  endtask

  task automatic drive_lu(input logic v, input int rd, input logic [WIDTH-1:0] d);
    lu_wb_valid = v;
    lu_wb_rd    = ADDR'(rd);
    lu_wb_data  = d;
  endtask

  task automatic long_issue(input int rd);
    drive_issue(1'b1, 0, 0, rd, 1'b1, 1'b1);
    settle;
    check($sformatf("issue_x%0d_stall", rd), stall, 1'b0);
    tick;
    drive_issue(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic lu_drain(input int rd);
    drive_lu(1'b1, rd, 32'h100 + WIDTH'(rd));
    settle;
    check($sformatf("drain_x%0d_ready", rd), lu_wb_ready, 1'b1);
    tick;
    drive_lu(1'b0, 0, '0);
  endtask

  initial begin
    reset = 1'b1;
    drive_issue(1'b0, 0, 0, 0, 1'b0, 1'b0);
    drive_alu(1'b0, 0, '0);
    drive_lu(1'b0, 0, '0);
    tick;
    tick;

    // Reset-time outputs, with both writeback sources requesting.
    drive_alu(1'b1, 3, 32'h1234);
    drive_lu(1'b1, 7, 32'h5678);
    settle;
    check("rst_stall", stall, 1'b1);
    check("rst_lu_ready", lu_wb_ready, 1'b0);
    check("rst_rf_wr_en", rf_wr_en, 1'b0);
    check("rst_rf_rd", rf_rd, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    tick;
    reset = 1'b0;
    drive_alu(1'b0, 0, '0);
    drive_lu(1'b0, 0, '0);
    settle;
    check("post_rst_pend", pend_cnt, 0);
    check("post_rst_err", sb_err, 1'b0);
    check("post_rst_stall", stall, 1'b0);
    tick;

    // RAW on a long load, released the cycle the LU writes it.
    long_issue(5);
    drive_issue(1'b1, 5, 0, 0, 1'b0, 1'b0);
    settle;
    check("raw_c1_stall", stall, 1'b1);
    check("raw_c1_pend", pend_cnt, 1);
    tick;
    settle;
    check("raw_c2_stall", stall, 1'b1);
    tick;
    drive_lu(1'b1, 5, 32'hDEAD);
    settle;
    check("raw_c3_stall", stall, 1'b0);
    check("raw_c3_wr_en", rf_wr_en, 1'b1);
    check("raw_c3_rd", rf_rd, 5);
    check("raw_c3_wdata", rf_wdata, 32'hDEAD);
    check("raw_c3_pend", pend_cnt, 1);
    tick;
    drive_issue(1'b0, 0, 0, 0, 1'b0, 1'b0);
    drive_lu(1'b0, 0, '0);
    settle;
    check("raw_c4_pend", pend_cnt, 0);
    check("raw_c4_wr_en", rf_wr_en, 1'b0);
    tick;

    // Port arbitration: ALU wins, LU next, ALU to x0 yields.
    long_issue(7);
    long_issue(8);
    drive_alu(1'b1, 3, 32'h1111);
    drive_lu(1'b1, 7, 32'h7777);
    settle;
    check("arb_alu_rd", rf_rd, 3);
    check("arb_alu_data", rf_wdata, 32'h1111);
    check("arb_lu_refused", lu_wb_ready, 1'b0);
    tick;
    drive_alu(1'b0, 0, '0);
    settle;
    check("arb_lu_rd", rf_rd, 7);
    check("arb_lu_data", rf_wdata, 32'h7777);
    check("arb_lu_ready", lu_wb_ready, 1'b1);
    tick;
    drive_alu(1'b1, 0, 32'hBAD);
    drive_lu(1'b1, 8, 32'h8888);
    settle;
    check("arb_x0_ready", lu_wb_ready, 1'b1);
    check("arb_x0_rd", rf_rd, 8);
    check("arb_x0_data", rf_wdata, 32'h8888);
    tick;
    drive_alu(1'b0, 0, '0);
    drive_lu(1'b0, 0, '0);
    settle;
    check("arb_pend", pend_cnt, 0);
    check("arb_err", sb_err, 1'b0);
    tick;

    // Capacity limit, relieved by a same-cycle LU completion.
    for (int r = 1; r <= 4; r++) long_issue(r);
    drive_issue(1'b1, 0, 0, 9, 1'b1, 1'b1);
    settle;
    check("full_stall", stall, 1'b1);
    check("full_pend", pend_cnt, 4);
    tick;
    drive_lu(1'b1, 1, 32'h1);
    settle;
    check("full_relief_stall", stall, 1'b0);
    tick;
    drive_issue(1'b0, 0, 0, 0, 1'b0, 1'b0);
    drive_lu(1'b0, 0, '0);
    settle;
    check("full_net_pend", pend_cnt, 4);
    drive_issue(1'b1, 0, 2, 0, 1'b0, 1'b0);
    settle;
    check("raw_rs2_stall", stall, 1'b1);
    drive_issue(1'b1, 0, 0, 9, 1'b1, 1'b0);
    settle;
    check("waw_stall", stall, 1'b1);
    drive_issue(1'b1, 1, 0, 1, 1'b1, 1'b0);
    settle;
    check("cleared_x1_stall", stall, 1'b0);
    drive_issue(1'b0, 0, 0, 0, 1'b0, 1'b0);
    tick;
    lu_drain(2);
    lu_drain(3);
    lu_drain(4);
    lu_drain(9);
    settle;
    check("drain_pend", pend_cnt, 0);
    tick;

    // Starvation: LU refused every cycle while the ALU hogs the port.
    long_issue(10);
    drive_alu(1'b1, 2, 32'h2222);
    drive_lu(1'b1, 10, 32'hA0A0);
    for (int k = 0; k <= 9; k++) begin
      settle;
      check($sformatf("starve_k%0d_ready", k), lu_wb_ready, 1'b0);
      check($sformatf("starve_k%0d_stall", k), stall, (k == 9));
      tick;
    end
    drive_alu(1'b0, 0, '0);
    settle;
    check("starve_fire_ready", lu_wb_ready, 1'b1);
    check("starve_fire_stall", stall, 1'b1);
    check("starve_fire_rd", rf_rd, 10);
    tick;
    drive_lu(1'b0, 0, '0);
    settle;
    check("starve_release", stall, 1'b0);
    check("starve_pend", pend_cnt, 0);
    tick;

    // x0 LU write accepted but not written; non-busy completion is an error.
    drive_lu(1'b1, 0, 32'hFFFF);
    settle;
    check("lu_x0_ready", lu_wb_ready, 1'b1);
    check("lu_x0_wr_en", rf_wr_en, 1'b0);
    tick;
    drive_lu(1'b1, 6, 32'h6666);
    settle;
    check("err_before", sb_err, 1'b0);
    tick;
    drive_lu(1'b0, 0, '0);
    settle;
    check("err_set", sb_err, 1'b1);
    check("err_pend", pend_cnt, 0);
    tick;
    long_issue(11);
    settle;
    check("err_sticky", sb_err, 1'b1);
    long_issue(1);
    long_issue(2);
    settle;
    check("pre_rst_pend", pend_cnt, 3);

    // Mid-operation reset discards busy tracking.
    reset = 1'b1;
    drive_lu(1'b1, 1, 32'h1);
    settle;
    check("mid_rst_stall", stall, 1'b1);
    check("mid_rst_ready", lu_wb_ready, 1'b0);
    tick;
    reset = 1'b0;
    drive_lu(1'b0, 0, '0);
    drive_issue(1'b1, 1, 2, 0, 1'b0, 1'b0);
    settle;
    check("mid_rst_err", sb_err, 1'b0);
    check("mid_rst_pend", pend_cnt, 0);
    check("mid_rst_rs1_stall", stall, 1'b0);
    tick;
    drive_issue(1'b0, 0, 0, 0, 1'b0, 1'b0);
    tick;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
